imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Shares the single-ported instruction/data memory between the fetch stage (port F) and the load/store unit (port D). It holds one pending request per port and arbitrates with data-priority and a starvation bound. It issues one transaction at a time to memory and routes the response back to the owner. Responses for fetches cancelled by a branch are discarded. It sits between `fetch_stage` / the memory stage and the memory wrapper.

## Interface
- `MAX_D_STREAK`, default 4: consecutive D grants allowed while F is pending before F is forced.
- `i_clk` in 1: clock.
- `i_reset` in 1: reset. Reset is asynchronous and active-high.
- `f_req_addr` in 32: fetch address. Sampled when `f_req_stb` is high.
- `f_req_stb` in 1: fetch request. Single-cycle pulse.
- `f_cancel` in 1: branch redirect (`exec_ld_pc`). Kills any pending or in-flight fetch.
- `f_req_data` out 32: fetch read data. Equals `m_rdata` when `f_req_valid`, else 0.
- `f_req_valid` out 1: fetch response pulse.
- `d_req_addr` in 32: data address.
- `d_req_stb` in 1: data request pulse.
- `d_req_we` in 1: write enable.
- `d_req_wdata` in 32: write data.
- `d_req_be` in 4: byte enables.
- `d_req_data` out 32: load data. Equals `m_rdata` when `d_req_valid`, else 0.
- `d_req_valid` out 1: data response pulse. Also pulses for writes.
- `m_addr` out 32: memory address. Registered.
- `m_stb` out 1: memory request. Registered.
- `m_we` out 1: memory write enable. Registered.
- `m_wdata` out 32: memory write data. Registered.
- `m_be` out 4: memory byte enables. Registered.
- `m_ready` in 1: memory accepts the request while `m_stb` is high.
- `m_rdata` in 32: memory read data.
- `m_rvalid` in 1: response pulse. Exactly one per accepted request, at least 1 cycle after acceptance, in order.

## Operation
- **Pending slots:** `pf` holds {addr}; `pd` holds {addr, we, wdata, be}.
  - A strobe loads its slot.
  - Requesters never strobe while their own slot is full or their request is in flight. The exception is F after `f_cancel`.
- **Cancel:** `f_cancel` clears `pf`.
  - An `f_req_stb` in the same cycle as `f_cancel` is ignored.
  - If the owner is F in state REQ or RESP, `discard` is set.
- **FSM states:**
  - IDLE: no memory transaction.
  - REQ: `m_stb` high, waiting for `m_ready`.
  - RESP: waiting for `m_rvalid`.
- **IDLE → REQ:** occurs when any candidate exists.
  - A candidate is a full slot, or a strobe arriving this cycle. The incoming request is treated as already pending.
  - The winner's fields load into the `m_*` registers and its slot is cleared.
  - Owner is recorded as F or D.
  - `discard` is cleared.
- **Arbitration:**
  - D wins if a D candidate exists, unless an F candidate exists and `streak == MAX_D_STREAK`.
  - Otherwise F wins.
- **Streak counter** (0..`MAX_D_STREAK`):
  - Increments on a D grant while an F candidate exists.
  - Clears on an F grant.
  - Clears on any cycle with no F candidate.
  - Saturates at `MAX_D_STREAK`.
- **REQ → RESP:** on `m_ready`. `m_stb` drops the next cycle. `m_stb` is never withdrawn before `m_ready`, including after a cancel.
- **RESP → IDLE:** on `m_rvalid`.
  - Owner D: `d_req_valid` = 1.
  - Owner F and `discard` = 0: `f_req_valid` = 1.
  - Owner F and `discard` = 1: no valid is raised and the data is dropped.
- **Response routing:** combinational from `m_rvalid`/`m_rdata`, state, owner and `discard`. A `f_cancel` in the same cycle as the matching `m_rvalid` suppresses `f_req_valid`.
- **Outputs under reset:**
  - `m_stb`, `m_we`, `f_req_valid` and `d_req_valid` are 0.
  - `m_addr`, `m_wdata` and `m_be` are 0.
  - `f_req_data` and `d_req_data` are 0.
- **Internal state under reset:**
  - State is IDLE.
  - `pf`, `pd`, `streak` and `discard` are cleared.
  - Reset mid-transaction abandons it. The memory wrapper is reset by the same signal.

## Timing
- Minimum stb→valid latency is 2 cycles:
  - Cycle 0: strobe.
  - Cycle 1: `m_stb` high and `m_ready` high.
  - Cycle 2: `m_rvalid`, and `*_req_valid` in the same cycle.
- Throughput is one transaction at a time.
- A candidate waiting in IDLE is issued on the same edge as the previous transaction's `m_rvalid`. `m_stb` rises the cycle after that response.
- `m_ready` held low keeps `m_stb` and all `m_*` fields stable.
- A strobe for a port arriving while that port's transaction is in flight (legal only for F after cancel) lands in the slot. It is issued after RESP completes.
- Simultaneous F and D strobes in IDLE: D issues, F is held in `pf`.

## Test plan
- **Single fetch:** F stb at cycle 0, addr 0x100; memory ready at once and rvalid at cycle 2 with data 0xDEADBEEF → `m_stb`/`m_addr` = 0x100 at cycle 1; `f_req_valid` = 1 with `f_req_data` = 0xDEADBEEF at cycle 2; `d_req_valid` stays 0.
- **Collision:** F (0x104) and D load (0x2000) strobe in the same cycle → D issued first; F issued the cycle after D's rvalid; each valid goes only to its owner.
- **Starvation bound** (`MAX_D_STREAK` = 4): F pending while D strobes back-to-back → exactly 4 D grants, then the F grant, then `streak` = 0.
- **Cancel in flight:** F 0x108 accepted, `f_cancel` in RESP, new F stb 0x200 the next cycle → rvalid for 0x108 gives no `f_req_valid`; 0x200 is issued afterwards and returns valid.
- **Cancel pending / same-cycle:** `f_cancel` while `pf` is full and D is in flight → `pf` is dropped and never reaches `m_stb`. `f_cancel` together with `f_req_stb` → no memory request.
- **Backpressure and reset:** `m_ready` low for 5 cycles → `m_*` stable, no valids. Assert `i_reset` during RESP → all outputs 0 immediately (async); after release a new F stb works normally.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if
//   Bundles the three buses around the instruction/data memory arbiter:
//   fetch port (f_*), load/store port (d_*) and the memory side (m_*).
//   Modports:
//     slave  - arbiter view: takes F/D requests and memory responses,
//              drives F/D responses and the memory request.
//     master - environment view (requesters plus memory wrapper).
interface imem_arbiter_if;
   logic [31:0] f_req_addr;
   logic        f_req_stb;
   logic        f_cancel;
   logic [31:0] f_req_data;
   logic        f_req_valid;

   logic [31:0] d_req_addr;
   logic        d_req_stb;
   logic        d_req_we;
   logic [31:0] d_req_wdata;
   logic [3:0]  d_req_be;
   logic [31:0] d_req_data;
   logic        d_req_valid;

   logic [31:0] m_addr;
   logic        m_stb;
   logic        m_we;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic        m_ready;
   logic [31:0] m_rdata;
   logic        m_rvalid;

   modport slave (
      input  f_req_addr, f_req_stb, f_cancel,
      input  d_req_addr, d_req_stb, d_req_we, d_req_wdata, d_req_be,
      input  m_ready, m_rdata, m_rvalid,
      output f_req_data, f_req_valid,
      output d_req_data, d_req_valid,
      output m_addr, m_stb, m_we, m_wdata, m_be
   );

   modport master (
      output f_req_addr, f_req_stb, f_cancel,
      output d_req_addr, d_req_stb, d_req_we, d_req_wdata, d_req_be,
      output m_ready, m_rdata, m_rvalid,
      input  f_req_data, f_req_valid,
      input  d_req_data, d_req_valid,
      input  m_addr, m_stb, m_we, m_wdata, m_be
   );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares one single-ported memory between the fetch stage (F) and the
//   load/store unit (D). One pending slot per port, data-priority
//   arbitration with a starvation bound for F, one memory transaction at a
//   time, responses routed back to the owner. Fetch responses killed by a
//   branch redirect (f_cancel) are dropped.
//   Ports:
//     i_clk    - clock
//     i_reset  - asynchronous active-high reset
//     bus      - imem_arbiter_if.slave (F port, D port, memory port)
//   Parameter:
//     MAX_D_STREAK - D grants allowed in a row while F waits
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no memory transaction
//   REQ   | m_stb high, waiting for m_ready
//   RESP  | request accepted, waiting for m_rvalid
module imem_arbiter #(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic           i_clk,
   input  logic           i_reset,
   imem_arbiter_if.slave  bus
);
   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   state_t state, state_n;

   logic          pf_full;
   logic [31:0]   pf_addr;
   logic          pd_full;
   logic [31:0]   pd_addr;
   logic          pd_we;
   logic [31:0]   pd_wdata;
   logic [3:0]    pd_be;

   logic          owner_d;
   logic          discard;
   logic [SW-1:0] streak;

   logic [31:0]   m_addr_q;
   logic          m_stb_q;
   logic          m_we_q;
   logic [31:0]   m_wdata_q;
   logic [3:0]    m_be_q;

   logic          f_cand;
   logic          d_cand;
   logic          win_d;
   logic          issue;
   logic          resp;

   // A strobe arriving this cycle counts as already pending; a cancel
   // removes every F candidate, including a same-cycle strobe.
   always_comb begin
      f_cand  = 1'b0;
      d_cand  = 1'b0;
      win_d   = 1'b0;
      issue   = 1'b0;
      resp    = 1'b0;
      state_n = state;

      f_cand = ~bus.f_cancel & (pf_full | bus.f_req_stb);
      d_cand = pd_full | bus.d_req_stb;
      win_d  = d_cand & ~(f_cand & (streak == STREAK_MAX));
      resp   = (state == RESP) & bus.m_rvalid;

      case (state)
         IDLE: begin
            if (f_cand | d_cand) begin
               issue   = 1'b1;
               state_n = REQ;
            end
         end
         REQ: begin
            if (bus.m_ready) state_n = RESP;
         end
         RESP: begin
            // The next candidate goes out on the same edge as the response.
            if (bus.m_rvalid) begin
               if (f_cand | d_cand) begin
                  issue   = 1'b1;
                  state_n = REQ;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= state_n;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pf_full   <= 1'b0;
         pf_addr   <= '0;
         pd_full   <= 1'b0;
         pd_addr   <= '0;
         pd_we     <= 1'b0;
         pd_wdata  <= '0;
         pd_be     <= '0;
         owner_d   <= 1'b0;
         discard   <= 1'b0;
         streak    <= '0;
         m_addr_q  <= '0;
         m_stb_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_wdata_q <= '0;
         m_be_q    <= '0;
      end else begin
         if (bus.f_cancel) begin
            pf_full <= 1'b0;
         end else if (issue && !win_d) begin
            pf_full <= 1'b0;
         end else if (bus.f_req_stb) begin
            pf_full <= 1'b1;
            pf_addr <= bus.f_req_addr;
         end

         if (issue && win_d) begin
            pd_full <= 1'b0;
         end else if (bus.d_req_stb) begin
            pd_full  <= 1'b1;
            pd_addr  <= bus.d_req_addr;
            pd_we    <= bus.d_req_we;
            pd_wdata <= bus.d_req_wdata;
            pd_be    <= bus.d_req_be;
         end

         if (issue) begin
            m_stb_q <= 1'b1;
            owner_d <= win_d;
            discard <= 1'b0;
            if (win_d) begin
               m_addr_q  <= pd_full ? pd_addr  : bus.d_req_addr;
               m_we_q    <= pd_full ? pd_we    : bus.d_req_we;
               m_wdata_q <= pd_full ? pd_wdata : bus.d_req_wdata;
               m_be_q    <= pd_full ? pd_be    : bus.d_req_be;
            end else begin
               m_addr_q  <= pf_full ? pf_addr : bus.f_req_addr;
               m_we_q    <= 1'b0;
               m_wdata_q <= '0;
               m_be_q    <= 4'hF;
            end
         end else begin
            if ((state == REQ) && bus.m_ready) m_stb_q <= 1'b0;
            // The request stays on the bus after a cancel; only its
            // response is dropped.
            if (bus.f_cancel && !owner_d && (state != IDLE)) discard <= 1'b1;
         end

         if (issue) begin
            if (win_d && f_cand)
               streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
            else
               streak <= '0;
         end else if (!f_cand) begin
            streak <= '0;
         end
      end
   end

   assign bus.m_addr  = m_addr_q;
   assign bus.m_stb   = m_stb_q;
   assign bus.m_we    = m_we_q;
   assign bus.m_wdata = m_wdata_q;
   assign bus.m_be    = m_be_q;

   assign bus.d_req_valid = resp & owner_d;
   assign bus.f_req_valid = resp & ~owner_d & ~discard & ~bus.f_cancel;
   assign bus.d_req_data  = bus.d_req_valid ? bus.m_rdata : 32'h0;
   assign bus.f_req_data  = bus.f_req_valid ? bus.m_rdata : 32'h0;
endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   imem_arbiter_if bus ();

   imem_arbiter #(.MAX_D_STREAK(4)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge and drop all pulses.
   task automatic cyc();
      @(posedge clk);
      #1;
      bus.f_req_stb   = 1'b0;
      bus.f_cancel    = 1'b0;
      bus.d_req_stb   = 1'b0;
      bus.d_req_we    = 1'b0;
      bus.d_req_wdata = 32'h0;
      bus.d_req_be    = 4'hF;
      bus.m_rvalid    = 1'b0;
      bus.m_rdata     = 32'h0;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_fv"}, {31'h0, bus.f_req_valid}, 32'h0);
      chk({tag, "_dv"}, {31'h0, bus.d_req_valid}, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.f_req_addr  = 32'h0;
      bus.f_req_stb   = 1'b0;
      bus.f_cancel    = 1'b0;
      bus.d_req_addr  = 32'h0;
      bus.d_req_stb   = 1'b0;
      bus.d_req_we    = 1'b0;
      bus.d_req_wdata = 32'h0;
      bus.d_req_be    = 4'hF;
      bus.m_ready     = 1'b1;
      bus.m_rdata     = 32'h0;
      bus.m_rvalid    = 1'b0;

      // reset values
      #2;
      chk("rst_m_stb",  {31'h0, bus.m_stb}, 32'h0);
      chk("rst_m_addr", bus.m_addr, 32'h0);
      chk("rst_m_be",   {28'h0, bus.m_be}, 32'h0);
      chk_quiet("rst");
      cyc();
      rst = 1'b0;
      cyc();

      // single fetch
      bus.f_req_stb = 1'b1; bus.f_req_addr = 32'h100;
      settle();
      chk("sf_c0_m_stb", {31'h0, bus.m_stb}, 32'h0);
      cyc(); settle();
      chk("sf_c1_m_stb",  {31'h0, bus.m_stb}, 32'h1);
      chk("sf_c1_m_addr", bus.m_addr, 32'h100);
      chk("sf_c1_m_we",   {31'h0, bus.m_we}, 32'h0);
      cyc();
      bus.m_rvalid = 1'b1; bus.m_rdata = 32'hDEADBEEF;
      settle();
      chk("sf_c2_fv",    {31'h0, bus.f_req_valid}, 32'h1);
      chk("sf_c2_fdata", bus.f_req_data, 32'hDEADBEEF);
      chk("sf_c2_dv",    {31'h0, bus.d_req_valid}, 32'h0);
      chk("sf_c2_m_stb", {31'h0, bus.m_stb}, 32'h0);
      cyc(); settle();
      chk_quiet("sf_c3");
      chk("sf_c3_fdata", bus.f_req_data, 32'h0);

      // collision: D first, F right after D's response
      cyc();
      bus.f_req_stb = 1'b1; bus.f_req_addr = 32'h104;
      bus.d_req_stb = 1'b1; bus.d_req_addr = 32'h2000;
      cyc(); settle();
      chk("col_d_addr", bus.m_addr, 32'h2000);
      chk("col_d_stb",  {31'h0, bus.m_stb}, 32'h1);
      cyc();
      bus.m_rvalid = 1'b1; bus.m_rdata = 32'h11111111;
      settle();
      chk("col_dv",    {31'h0, bus.d_req_valid}, 32'h1);
      chk("col_ddata", bus.d_req_data, 32'h11111111);
      chk("col_fv0",   {31'h0, bus.f_req_valid}, 32'h0);
      cyc(); settle();
      chk("col_f_stb",  {31'h0, bus.m_stb}, 32'h1);
      chk("col_f_addr", bus.m_addr, 32'h104);
      cyc();
      bus.m_rvalid = 1'b1; bus.m_rdata = 32'h22222222;
      settle();
      chk("col_fv",    {31'h0, bus.f_req_valid}, 32'h1);
      chk("col_fdata", bus.f_req_data, 32'h22222222);
      chk("col_dv0",   {31'h0, bus.d_req_valid}, 32'h0);

      // starvation bound: 4 D grants then F
      cyc();
      bus.f_req_stb = 1'b1; bus.f_req_addr = 32'h300;
      bus.d_req_stb = 1'b1; bus.d_req_addr = 32'h3000;
      for (int k = 0; k < 4; k++) begin
         cyc(); settle();
         chk($sformatf("stv_d%0d_stb", k),  {31'h0, bus.m_stb}, 32'h1);
         chk($sformatf("stv_d%0d_addr", k), bus.m_addr, 32'h3000 + 32'(4 * k));
         if (k == 1) begin
            chk("stv_wr_we",    {31'h0, bus.m_we}, 32'h1);
            chk("stv_wr_wdata", bus.m_wdata, 32'hCAFE0001);
            chk("stv_wr_be",    {28'h0, bus.m_be}, 32'h3);
         end
         cyc();
         bus.m_rvalid = 1'b1; bus.m_rdata = 32'h5000 + 32'(k);
         bus.d_req_stb = 1'b1; bus.d_req_addr = 32'h3000 + 32'(4 * (k + 1));
         if (k == 0) begin
            bus.d_req_we = 1'b1; bus.d_req_wdata = 32'hCAFE0001; bus.d_req_be = 4'h3;
         end
         settle();
         chk($sformatf("stv_d%0d_dv", k), {31'h0, bus.d_req_valid}, 32'h1);
         chk($sformatf("stv_d%0d_fv", k), {31'h0, bus.f_req_valid}, 32'h0);
      end
      chk("stv_streak_max", 32'(dut.streak), 32'd4);
      cyc(); settle();
      chk("stv_f_addr",   bus.m_addr, 32'h300);
      chk("stv_streak_0", 32'(dut.streak), 32'd0);
      cyc();
      bus.m_rvalid = 1'b1; bus.m_rdata = 32'h33333333;
      settle();
      chk("stv_fv",    {31'h0, bus.f_req_valid}, 32'h1);
      chk("stv_fdata", bus.f_req_data, 32'h33333333);
      cyc(); settle();
      chk("stv_d4_addr", bus.m_addr, 32'h3010);
      cyc();
      bus.m_rvalid = 1'b1; bus.m_rdata = 32'h44444444;
      settle();
      chk("stv_d4_dv", {31'h0, bus.d_req_valid}, 32'h1);

      // cancel in flight
      cyc();
      bus.f_req_stb = 1'b1; bus.f_req_addr = 32'h108;
      cyc(); settle();
      chk("cif_addr", bus.m_addr, 32'h108);
      cyc();
      bus.f_cancel = 1'b1;
      settle();
      chk("cif_cancel_fv", {31'h0, bus.f_req_valid}, 32'h0);
      cyc();
      bus.f_req_stb = 1'b1; bus.f_req_addr = 32'h200;
      cyc();
      bus.m_rvalid = 1'b1; bus.m_rdata = 32'h0BAD0BAD;
      settle();
      chk_quiet("cif_stale");
      chk("cif_stale_fdata", bus.f_req_data, 32'h0);
      cyc(); settle();
      chk("cif_new_stb",  {31'h0, bus.m_stb}, 32'h1);
      chk("cif_new_addr", bus.m_addr, 32'h200);
      cyc();
      bus.m_rvalid = 1'b1; bus.m_rdata = 32'h12345678;
      settle();
      chk("cif_new_fv",    {31'h0, bus.f_req_valid}, 32'h1);
      chk("cif_new_fdata", bus.f_req_data, 32'h12345678);

      // cancel pending while D in flight
      cyc();
      bus.f_req_stb = 1'b1; bus.f_req_addr = 32'h400;
      bus.d_req_stb = 1'b1; bus.d_req_addr = 32'h4000;
      cyc();
      bus.f_cancel = 1'b1;
      settle();
      chk("cp_d_addr", bus.m_addr, 32'h4000);
      cyc();
      bus.m_rvalid = 1'b1; bus.m_rdata = 32'h40404040;
      settle();
      chk("cp_dv", {31'h0, bus.d_req_valid}, 32'h1);
      cyc(); settle();
      chk("cp_no_stb_a", {31'h0, bus.m_stb}, 32'h0);
      cyc(); settle();
      chk("cp_no_stb_b", {31'h0, bus.m_stb}, 32'h0);

      // cancel together with strobe
      cyc();
      bus.f_req_stb = 1'b1; bus.f_req_addr = 32'h500; bus.f_cancel = 1'b1;
      cyc(); settle();
      chk("cs_no_stb_a", {31'h0, bus.m_stb}, 32'h0);
      cyc(); settle();
      chk("cs_no_stb_b", {31'h0, bus.m_stb}, 32'h0);

      // backpressure
      bus.m_ready = 1'b0;
      cyc();
      bus.d_req_stb = 1'b1; bus.d_req_addr = 32'h6000;
      bus.d_req_we = 1'b1; bus.d_req_wdata = 32'hA5A5A5A5; bus.d_req_be = 4'hC;
      for (int k = 0; k < 5; k++) begin
         cyc(); settle();
         chk($sformatf("bp%0d_stb", k),   {31'h0, bus.m_stb}, 32'h1);
         chk($sformatf("bp%0d_addr", k),  bus.m_addr, 32'h6000);
         chk($sformatf("bp%0d_we", k),    {31'h0, bus.m_we}, 32'h1);
         chk($sformatf("bp%0d_wdata", k), bus.m_wdata, 32'hA5A5A5A5);
         chk($sformatf("bp%0d_be", k),    {28'h0, bus.m_be}, 32'hC);
         chk_quiet($sformatf("bp%0d", k));
      end
      bus.m_ready = 1'b1;
      cyc(); settle();
      chk("bp_accepted_stb", {31'h0, bus.m_stb}, 32'h0);

      // async reset during RESP
      bus.m_rvalid = 1'b1; bus.m_rdata = 32'hFFFFFFFF;
      rst = 1'b1;
      #1;
      chk("ar_m_stb",   {31'h0, bus.m_stb}, 32'h0);
      chk("ar_m_addr",  bus.m_addr, 32'h0);
      chk("ar_m_wdata", bus.m_wdata, 32'h0);
      chk("ar_m_we",    {31'h0, bus.m_we}, 32'h0);
      chk("ar_m_be",    {28'h0, bus.m_be}, 32'h0);
      chk_quiet("ar");
      chk("ar_ddata", bus.d_req_data, 32'h0);
      chk("ar_fdata", bus.f_req_data, 32'h0);
      cyc();
      rst = 1'b0;
      cyc();
      bus.f_req_stb = 1'b1; bus.f_req_addr = 32'h700;
      cyc(); settle();
      chk("pr_stb",  {31'h0, bus.m_stb}, 32'h1);
      chk("pr_addr", bus.m_addr, 32'h700);
      cyc();
      bus.m_rvalid = 1'b1; bus.m_rdata = 32'h77777777;
      settle();
      chk("pr_fv",    {31'h0, bus.f_req_valid}, 32'h1);
      chk("pr_fdata", bus.f_req_data, 32'h77777777);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
